// File: rtl/fetch_pkg.sv
// Shared types for the instruction-fetch request controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fetch_pkg;

  // Controller states: IDLE waits for a PC, REQ drives a live request,
  // KILL drives a request whose return has already been flushed.
  typedef enum logic [1:0] {
    FETCH_ST_IDLE = 2'd0,
    FETCH_ST_REQ  = 2'd1,
    FETCH_ST_KILL = 2'd2
  } fetch_st_e;

  localparam int FETCH_PC_W   = 32;
  localparam int FETCH_DAT_W  = 64;
  localparam int FETCH_PAIR_W = FETCH_PC_W + FETCH_DAT_W;  // {PC, data}

endpackage

// File: rtl/fetch_req_ctrl_if.sv
// Bundle of the PreIF, instruction-port and IF-response signals.
// Latency: n/a (wires only).
// Backpressure: pc_ready_o / inst_sram_addr_ok_i / rsp_ready_i handshakes.
// Modports: master = fetch_req_ctrl, slave = surrounding pipeline and port.
interface fetch_req_ctrl_if;
  logic        pc_valid_i;
  logic [31:0] pc_i;
  logic        pc_ready_o;
  logic        flush_i;
  logic        inst_sram_req_o;
  logic [31:0] inst_sram_addr_o;
  logic        inst_sram_addr_ok_i;
  logic        inst_sram_data_ok_i;
  logic [63:0] inst_sram_rdata_i;
  logic        rsp_valid_o;
  logic [31:0] rsp_pc_o;
  logic [63:0] rsp_inst_o;
  logic        rsp_ready_i;

  modport master (
    input  pc_valid_i, pc_i, flush_i,
    input  inst_sram_addr_ok_i, inst_sram_data_ok_i, inst_sram_rdata_i,
    input  rsp_ready_i,
    output pc_ready_o, inst_sram_req_o, inst_sram_addr_o,
    output rsp_valid_o, rsp_pc_o, rsp_inst_o
  );

  modport slave (
    output pc_valid_i, pc_i, flush_i,
    output inst_sram_addr_ok_i, inst_sram_data_ok_i, inst_sram_rdata_i,
    output rsp_ready_i,
    input  pc_ready_o, inst_sram_req_o, inst_sram_addr_o,
    input  rsp_valid_o, rsp_pc_o, rsp_inst_o
  );
endinterface

// File: rtl/fetch_fifo.sv
// Synchronous circular FIFO with a synchronous clear.
// Latency: push visible at head one cycle later; head is a combinational read.
// Backpressure: push ignored when full unless a pop happens the same cycle.
// Ports: clk/rst, clr, push/push_dat, pop/head_dat, empty, full, count.
module fetch_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 2,
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          push,
  input  logic [W-1:0]  push_dat,
  input  logic          pop,
  output logic [W-1:0]  head_dat,
  output logic          empty,
  output logic          full,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign head_dat = mem[rd_ptr];

  // Storage is reset too so the head reads zero straight out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (do_pop) rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fetch_req_ctrl.sv
// Central owner of the instruction port: issues fetch PCs, tracks in-flight
// requests by credit, discards flushed returns, queues {PC, data} for IF.
// Latency: PC accept N -> req N+1; data_ok K -> rsp_valid_o K+1.
// Backpressure: pc_ready_o drops once in-flight + buffered fetches reach
// MAX_OUT; rsp_ready_i low holds responses in the rsp FIFO.
// Ports: clk, rst (async active-high), bus (fetch_req_ctrl_if.master).
// Optional macro FETCH_REQ_PERF_EN adds perf_issue_o / perf_drop_o counters.
module fetch_req_ctrl
  import fetch_pkg::*;
#(
  parameter int MAX_OUT = 2,
  parameter int CNT_W   = 2
) (
  input  logic               clk,
  input  logic               rst,
  fetch_req_ctrl_if.master   bus
`ifdef FETCH_REQ_PERF_EN
  ,
  output logic [31:0]        perf_issue_o,
  output logic [31:0]        perf_drop_o
`endif
);

  localparam int FC_W   = $clog2(MAX_OUT + 1);
  localparam int CRED_W = $clog2(3 * MAX_OUT + 2);

  fetch_st_e          state, state_nxt;
  logic [31:0]        req_pc;
  logic [CNT_W-1:0]   out_cnt, dis_cnt, out_nxt, dis_nxt;
  logic [CRED_W-1:0]  credit;
  logic               pc_rdy, pc_acc, addr_acc, kill_acc, drop_ret, rsp_push;
  logic [31:0]        pcq_head;
  logic               pcq_empty, pcq_full, rsq_empty, rsq_full;
  logic [FC_W-1:0]    pcq_count, rsq_count;
  logic [FETCH_PAIR_W-1:0] rsq_head;

  // Every fetch holds one credit from PC accept until it is consumed by IF
  // or discarded.
  assign credit = CRED_W'(out_cnt) + CRED_W'(rsq_count) +
                  CRED_W'(state != FETCH_ST_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= FETCH_ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pc_rdy    = 1'b0;
    bus.inst_sram_req_o = 1'b0;
    case (state)
      FETCH_ST_IDLE: begin
        pc_rdy = !bus.flush_i && (credit < CRED_W'(MAX_OUT));
        if (bus.pc_valid_i && pc_rdy) state_nxt = FETCH_ST_REQ;
      end
      FETCH_ST_REQ: begin
        bus.inst_sram_req_o = 1'b1;
        if (bus.inst_sram_addr_ok_i) state_nxt = FETCH_ST_IDLE;
        else if (bus.flush_i)        state_nxt = FETCH_ST_KILL;
      end
      FETCH_ST_KILL: begin
        // A raised req cannot be withdrawn; finish it and drop the return.
        bus.inst_sram_req_o = 1'b1;
        if (bus.inst_sram_addr_ok_i) state_nxt = FETCH_ST_IDLE;
      end
      default: state_nxt = FETCH_ST_IDLE;
    endcase
  end

  assign bus.pc_ready_o       = pc_rdy;
  assign bus.inst_sram_addr_o = req_pc;

  assign pc_acc   = bus.pc_valid_i && pc_rdy;
  assign addr_acc = (state != FETCH_ST_IDLE) && bus.inst_sram_addr_ok_i;
  assign kill_acc = (state == FETCH_ST_KILL) && bus.inst_sram_addr_ok_i;
  assign drop_ret = bus.inst_sram_data_ok_i && (dis_cnt != '0);
  assign rsp_push = bus.inst_sram_data_ok_i && (dis_cnt == '0) && !bus.flush_i;

  // On flush every request still owed a return becomes a discard, including
  // one accepted this very cycle; a return arriving now is already gone.
  always_comb begin
    out_nxt = out_cnt + CNT_W'(addr_acc) - CNT_W'(bus.inst_sram_data_ok_i);
    dis_nxt = dis_cnt + CNT_W'(kill_acc) - CNT_W'(drop_ret);
    if (bus.flush_i) dis_nxt = out_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_pc  <= '0;
      out_cnt <= '0;
      dis_cnt <= '0;
    end else begin
      if (pc_acc) req_pc <= bus.pc_i;
      out_cnt <= out_nxt;
      dis_cnt <= dis_nxt;
    end
  end

  // PCs of requests on the bus, returned in order alongside their data.
  fetch_fifo #(.W(FETCH_PC_W), .DEPTH(MAX_OUT)) u_pc_q (
    .clk      (clk),
    .rst      (rst),
    .clr      (1'b0),
    .push     (addr_acc),
    .push_dat (req_pc),
    .pop      (bus.inst_sram_data_ok_i),
    .head_dat (pcq_head),
    .empty    (pcq_empty),
    .full     (pcq_full),
    .count    (pcq_count)
  );

  fetch_fifo #(.W(FETCH_PAIR_W), .DEPTH(MAX_OUT)) u_rsp_q (
    .clk      (clk),
    .rst      (rst),
    .clr      (bus.flush_i),
    .push     (rsp_push),
    .push_dat ({pcq_head, bus.inst_sram_rdata_i}),
    .pop      (bus.rsp_valid_o && bus.rsp_ready_i),
    .head_dat (rsq_head),
    .empty    (rsq_empty),
    .full     (rsq_full),
    .count    (rsq_count)
  );

  assign bus.rsp_valid_o = !rsq_empty;
  assign bus.rsp_pc_o    = rsq_head[FETCH_PAIR_W-1:FETCH_DAT_W];
  assign bus.rsp_inst_o  = rsq_head[FETCH_DAT_W-1:0];

`ifdef FETCH_REQ_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_issue_o <= '0;
      perf_drop_o  <= '0;
    end else begin
      if (addr_acc) perf_issue_o <= perf_issue_o + 32'd1;
      if (drop_ret) perf_drop_o  <= perf_drop_o + 32'd1;
    end
  end
`endif

  a_no_orphan_ret: assert property (@(posedge clk) disable iff (rst)
    bus.inst_sram_data_ok_i |-> !pcq_empty);
  a_pcq_no_ovf: assert property (@(posedge clk) disable iff (rst)
    addr_acc |-> (!pcq_full || bus.inst_sram_data_ok_i));
  a_rsq_no_ovf: assert property (@(posedge clk) disable iff (rst)
    rsp_push |-> (!rsq_full || bus.rsp_ready_i));
  a_out_tracks_q: assert property (@(posedge clk) disable iff (rst)
    CNT_W'(pcq_count) == out_cnt);

endmodule

// File: tb/tb_fetch_req_ctrl.sv
module tb_fetch_req_ctrl;

  localparam int MAX_OUT = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fetch_req_ctrl_if intf ();

`ifdef FETCH_REQ_PERF_EN
  logic [31:0] perf_issue_o, perf_drop_o;
`endif

  fetch_req_ctrl #(.MAX_OUT(MAX_OUT), .CNT_W(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (intf)
`ifdef FETCH_REQ_PERF_EN
    ,
    .perf_issue_o (perf_issue_o),
    .perf_drop_o  (perf_drop_o)
`endif
  );

  // Reference model: every accepted fetch carries the flush epoch it was
  // accepted in; a fetch is delivered only if no flush happened between its
  // acceptance and its return, and a buffered response is lost on a flush.
  typedef struct { logic [31:0] pc; int ep; } bus_t;
  typedef struct { logic [31:0] pc; logic [63:0] dat; } rsp_t;

  bus_t        slave_q[$];
  rsp_t        exp_q[$];
  bit          pending;
  logic [31:0] pend_pc;
  int          pend_ep;
  int          epoch;
  int          m_issue, m_drop;
  int          tests, fails;

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_idle();
    intf.pc_valid_i          = 1'b0;
    intf.pc_i                = '0;
    intf.flush_i             = 1'b0;
    intf.inst_sram_addr_ok_i = 1'b0;
    intf.inst_sram_data_ok_i = 1'b0;
    intf.inst_sram_rdata_i   = '0;
    intf.rsp_ready_i         = 1'b0;
  endtask

  task automatic model_clear();
    slave_q.delete();
    exp_q.delete();
    pending = 1'b0;
    m_issue = 0;
    m_drop  = 0;
  endtask

  // One clock cycle, entered and left at a falling edge.
  task automatic cyc(input bit fl, input bit pv, input logic [31:0] pc,
                     input bit aok, input bit dok, input logic [63:0] rd,
                     input bit rr);
    bit   a_eff, d_eff, r_eff, exp_rdy;
    bus_t it;
    rsp_t r;
    check("rsp_valid", 96'(intf.rsp_valid_o), 96'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      check("rsp_pc", 96'(intf.rsp_pc_o), 96'(exp_q[0].pc));
      check("rsp_inst", 96'(intf.rsp_inst_o), 96'(exp_q[0].dat));
    end
    check("req", 96'(intf.inst_sram_req_o), 96'(pending));
    if (pending) check("addr", 96'(intf.inst_sram_addr_o), 96'(pend_pc));
`ifdef FETCH_REQ_PERF_EN
    check("perf_issue", 96'(perf_issue_o), 96'(m_issue));
    check("perf_drop", 96'(perf_drop_o), 96'(m_drop));
`endif
    a_eff = aok && pending;
    d_eff = dok && (slave_q.size() != 0);
    r_eff = rr && !fl;
    intf.flush_i             = fl;
    intf.pc_valid_i          = pv;
    intf.pc_i                = pc;
    intf.inst_sram_addr_ok_i = a_eff;
    intf.inst_sram_data_ok_i = d_eff;
    intf.inst_sram_rdata_i   = rd;
    intf.rsp_ready_i         = r_eff;
    exp_rdy = !fl && !pending && ((slave_q.size() + exp_q.size()) < MAX_OUT);
    #1;
    check("pc_ready", 96'(intf.pc_ready_o), 96'(exp_rdy));
    if (r_eff && exp_q.size() != 0) exp_q.delete(0);
    if (d_eff) begin
      it = slave_q.pop_front();
      if (it.ep != epoch) m_drop++;
      else if (!fl) begin
        r.pc  = it.pc;
        r.dat = rd;
        exp_q.push_back(r);
      end
    end
    if (a_eff) begin
      it.pc = pend_pc;
      it.ep = pend_ep;
      slave_q.push_back(it);
      pending = 1'b0;
      m_issue++;
    end
    if (pv && exp_rdy) begin
      pending = 1'b1;
      pend_pc = pc;
      pend_ep = epoch;
    end
    if (fl) begin
      exp_q.delete();
      epoch++;
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n, input bit rr);
    for (int k = 0; k < n; k++) cyc(0, 0, '0, 0, 0, '0, rr);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"}, 96'(intf.inst_sram_req_o), 96'(0));
    check({tag, "_addr"}, 96'(intf.inst_sram_addr_o), 96'(0));
    check({tag, "_rsp_valid"}, 96'(intf.rsp_valid_o), 96'(0));
    check({tag, "_rsp_pc"}, 96'(intf.rsp_pc_o), 96'(0));
    check({tag, "_rsp_inst"}, 96'(intf.rsp_inst_o), 96'(0));
    check({tag, "_pc_ready"}, 96'(intf.pc_ready_o), 96'(1));
`ifdef FETCH_REQ_PERF_EN
    check({tag, "_perf_issue"}, 96'(perf_issue_o), 96'(0));
    check({tag, "_perf_drop"}, 96'(perf_drop_o), 96'(0));
`endif
  endtask

  // Reset asserted between edges; the port side is reset with it.
  task automatic do_reset();
    #2;
    drive_idle();
    rst = 1'b1;
    #1;
    check_reset_outputs("rst_async");
    model_clear();
    @(posedge clk);
    #1;
    check_reset_outputs("rst_edge");
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    epoch = 0;
    model_clear();
    drive_idle();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    // Single fetch: accept, addr_ok with req, data_ok two cycles later.
    cyc(0, 1, 32'h1C00_0000, 0, 0, '0, 1);
    check("t1_req", 96'(intf.inst_sram_req_o), 96'(1));
    cyc(0, 0, '0, 1, 0, '0, 0);
    idle(1, 0);
    cyc(0, 0, '0, 0, 1, 64'hAAAA_BBBB_CCCC_DDDD, 0);
    check("t1_valid", 96'(intf.rsp_valid_o), 96'(1));
    check("t1_pc", 96'(intf.rsp_pc_o), 96'(32'h1C00_0000));
    check("t1_inst", 96'(intf.rsp_inst_o), 96'(64'hAAAA_BBBB_CCCC_DDDD));
    idle(1, 1);

    // IF stalled: two returns fill the credit.
    cyc(0, 1, 32'h0000_1000, 0, 0, '0, 0);
    cyc(0, 0, '0, 1, 0, '0, 0);
    cyc(0, 1, 32'h0000_1008, 0, 0, '0, 0);
    cyc(0, 0, '0, 1, 0, '0, 0);
    cyc(0, 0, '0, 0, 1, 64'h1111, 0);
    cyc(0, 0, '0, 0, 1, 64'h2222, 0);
    check("t2_full_rdy", 96'(intf.pc_ready_o), 96'(0));
    check("t2_head_pc", 96'(intf.rsp_pc_o), 96'(32'h0000_1000));
    idle(2, 1);
    check("t2_drained_rdy", 96'(intf.pc_ready_o), 96'(1));

    // Flush while requesting without addr_ok: req is held, return dropped.
    cyc(0, 1, 32'h0000_2000, 0, 0, '0, 1);
    cyc(1, 0, '0, 0, 0, '0, 1);
    check("t3_req_held", 96'(intf.inst_sram_req_o), 96'(1));
    check("t3_addr_held", 96'(intf.inst_sram_addr_o), 96'(32'h0000_2000));
    cyc(0, 0, '0, 1, 0, '0, 1);
    cyc(0, 0, '0, 0, 1, 64'h3333, 1);
    check("t3_dropped", 96'(intf.rsp_valid_o), 96'(0));

    // Two outstanding, flush together with the first return.
    cyc(0, 1, 32'h0000_3000, 0, 0, '0, 1);
    cyc(0, 0, '0, 1, 0, '0, 1);
    cyc(0, 1, 32'h0000_3008, 0, 0, '0, 1);
    cyc(0, 0, '0, 1, 0, '0, 1);
    cyc(1, 0, '0, 0, 1, 64'h4444, 0);
    cyc(0, 0, '0, 0, 1, 64'h5555, 0);
    check("t4_dropped", 96'(intf.rsp_valid_o), 96'(0));
    cyc(0, 1, 32'h0000_3010, 0, 0, '0, 0);
    cyc(0, 0, '0, 1, 0, '0, 0);
    cyc(0, 0, '0, 0, 1, 64'h6666, 0);
    check("t4_new_pc", 96'(intf.rsp_pc_o), 96'(32'h0000_3010));
    check("t4_new_inst", 96'(intf.rsp_inst_o), 96'(64'h6666));
    idle(1, 1);

    // Flush with two buffered responses.
    cyc(0, 1, 32'h0000_4000, 0, 0, '0, 0);
    cyc(0, 0, '0, 1, 0, '0, 0);
    cyc(0, 1, 32'h0000_4008, 0, 0, '0, 0);
    cyc(0, 0, '0, 1, 0, '0, 0);
    cyc(0, 0, '0, 0, 1, 64'h7777, 0);
    cyc(0, 0, '0, 0, 1, 64'h8888, 0);
    cyc(1, 0, '0, 0, 0, '0, 0);
    check("t5_cleared", 96'(intf.rsp_valid_o), 96'(0));
    idle(1, 0);

    // Reset in the middle of a request.
    cyc(0, 1, 32'h0000_5000, 0, 0, '0, 0);
    do_reset();

    // Randomised traffic against the model, with one reset in the middle.
    for (int i = 0; i < 1500; i++) begin
      if (i == 700) do_reset();
      cyc($urandom_range(0, 11) == 0, $urandom_range(0, 1) == 1,
          $urandom & 32'hFFFF_FFF8, $urandom_range(0, 2) != 0,
          $urandom_range(0, 2) == 0, {$urandom, $urandom},
          $urandom_range(0, 3) != 0);
    end
    idle(4, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fetch_req_ctrl.md
# fetch_req_ctrl

Sequences instruction-fetch requests between the PreIF stage and the SRAM-like instruction port (req/addr_ok/data_ok). It tracks outstanding requests with a credit counter. On exception or branch flush it marks in-flight requests for discard instead of cancelling them on the bus. Returned 64-bit fetch pairs are queued with their PC for the IF stage, replacing ad-hoc per-stage cancel flags with one central owner of the instruction port.

## Interface
- `MAX_OUT`, 2: maximum in-flight plus buffered fetches (≥1).
- `CNT_W`, 2: width of outstanding/discard counters (holds 0..MAX_OUT).
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `pc_valid_i` in 1: PreIF offers a fetch PC.
- `pc_i` in 32: fetch PC (8-byte aligned).
- `pc_ready_o` out 1: fetch PC accepted this cycle.
- `flush_i` in 1: exception or branch flush; kills all older fetches.
- `inst_sram_req_o` out 1: request to instruction port.
- `inst_sram_addr_o` out 32: request address.
- `inst_sram_addr_ok_i` in 1: request accepted by port.
- `inst_sram_data_ok_i` in 1: one response returned, in request order.
- `inst_sram_rdata_i` in 64: response data.
- `rsp_valid_o` out 1: fetch pair available to IF.
- `rsp_pc_o` out 32: PC of head response.
- `rsp_inst_o` out 64: data of head response.
- `rsp_ready_i` in 1: IF consumes head response.

## Operation
- Counters: `out_cnt` counts addr_ok'd responses not yet returned. `dis_cnt` (≤ out_cnt) counts returns still to be dropped. `credit = out_cnt + rsp_fifo count + (state≠IDLE)`.
- States:
  - IDLE: `pc_ready_o = !flush_i && credit < MAX_OUT`. On accept, latch `pc_i` and go to REQ.
  - REQ: `inst_sram_req_o=1` with latched addr. On addr_ok: push PC to pc queue, `out_cnt+1`, go to IDLE. On flush without addr_ok: go to KILL.
  - KILL: req stays asserted with the same addr; the bus rule forbids withdrawing req. On addr_ok: push PC, `out_cnt+1`, `dis_cnt+1`, go to IDLE.
- data_ok: pop pc queue, `out_cnt-1`. If `dis_cnt>0` (pre-update), drop the data and `dis_cnt-1`. Otherwise push {PC, rdata} into rsp FIFO.
- flush_i:
  - rsp FIFO cleared.
  - `dis_cnt_next = out_cnt_next`. This includes an addr_ok and excludes a data_ok in the same cycle.
  - Any data_ok in the flush cycle is dropped.
  - REQ with same-cycle addr_ok goes to IDLE and that request counts as discarded.
- The credit rule guarantees the rsp FIFO never overflows. data_ok with an empty pc queue is a protocol error; the assertion fires.

## Timing
- Reset values: state IDLE, counters 0, `inst_sram_req_o=0`, `inst_sram_addr_o=0`, `rsp_valid_o=0`, `rsp_pc_o=0`, `rsp_inst_o=0`.
- `pc_ready_o=1` in the first cycle after reset when flush_i is low.
- PC accepted in cycle N → `inst_sram_req_o` high in N+1.
- addr_ok in cycle M → IDLE in M+1, next accept earliest M+1, so issue rate is one request per 2 cycles.
- data_ok in cycle K → `rsp_valid_o` in K+1 (registered FIFO, no bypass).
- Pop on `rsp_valid_o && rsp_ready_i`. Push and pop may occur in the same cycle.
- Reset asserted mid-transaction clears all state immediately. The port must be reset alongside.

## Configuration
- `FETCH_REQ_PERF_EN`:
  - Defined: adds outputs `perf_issue_o[31:0]` (addr_ok count) and `perf_drop_o[31:0]` (discarded returns). Both wrap at 2^32 and reset to 0.
  - Undefined: the ports and counters are absent.

## Structure
- Shared package `fetch_pkg`: the `FETCH_ST_IDLE/REQ/KILL` encodings and `FETCH_PAIR_W=96` ({PC, data} width).
- One sub-module, `fetch_fifo`: synchronous, parameterised width/depth, with clear input.
  - Instantiated twice: pc queue (32 bits) and rsp FIFO (96 bits).

## Test plan
- Reset, then PC 0x1C000000, addr_ok same cycle as req, data_ok 2 cycles later with 0xAAAA_BBBB_CCCC_DDDD → `rsp_valid_o` with that PC and data one cycle after data_ok.
- `rsp_ready_i=0`, issue 2 PCs → after 2 returns `pc_ready_o` stays 0 (credit=2). Raise ready → two responses in order, then ready returns to 1.
- Flush while in REQ without addr_ok → req held with same addr. On addr_ok and data_ok the data is dropped and `rsp_valid_o` stays 0.
- 2 outstanding, flush with data_ok in the same cycle → both returns dropped, `dis_cnt` ends at 0, a new PC is accepted and delivered normally.
- Flush with 2 buffered responses → `rsp_valid_o=0` next cycle. With `FETCH_REQ_PERF_EN`, `perf_drop_o` increments only for returns dropped by `dis_cnt`.
- Assert rst mid-REQ → next edge all outputs at reset values, `pc_ready_o=1`.
